// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Two-requester round-robin arbiter for a shared register write
//               port. Every write is a one-cycle load pulse followed by an
//               acknowledge phase. All outputs come straight from flops.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             enabling,
    output logic [WIDTH-1:0] wr_data,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             done_a,
    output logic             done_b,
    output logic [7:0]       wr_count
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD_A = 3'd1;
    localparam logic [2:0] c_LOAD_B = 3'd2;
    localparam logic [2:0] c_ACK_A  = 3'd3;
    localparam logic [2:0] c_ACK_B  = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic             r_ptr;
    logic             r_enabling;
    logic [WIDTH-1:0] r_wr_data;
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic             r_done_a;
    logic             r_done_b;
    logic [7:0]       r_wr_count;
    logic             w_in_load;

    assign w_in_load = (r_state == c_LOAD_A) || (r_state == c_LOAD_B);

    // The pointer only matters when both requests are present in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (req_a && (!req_b || !r_ptr)) begin
                    w_state_nxt = c_LOAD_A;
                end else if (req_b) begin
                    w_state_nxt = c_LOAD_B;
                end
            end
            c_LOAD_A: w_state_nxt = c_ACK_A;
            c_LOAD_B: w_state_nxt = c_ACK_B;
            c_ACK_A:  if (!req_a) w_state_nxt = c_IDLE;
            c_ACK_B:  if (!req_b) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are valid in the same
    // cycle the state register enters the corresponding state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_ptr      <= 1'b0;
            r_enabling <= 1'b0;
            r_wr_data  <= '0;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_done_a   <= 1'b0;
            r_done_b   <= 1'b0;
            r_wr_count <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_enabling <= (w_state_nxt == c_LOAD_A) || (w_state_nxt == c_LOAD_B);
            r_gnt_a    <= (w_state_nxt == c_LOAD_A) || (w_state_nxt == c_ACK_A);
            r_gnt_b    <= (w_state_nxt == c_LOAD_B) || (w_state_nxt == c_ACK_B);
            r_done_a   <= (w_state_nxt == c_ACK_A);
            r_done_b   <= (w_state_nxt == c_ACK_B);
            if (w_state_nxt == c_LOAD_A) begin
                r_wr_data <= data_a;
            end else if (w_state_nxt == c_LOAD_B) begin
                r_wr_data <= data_b;
            end
            if (w_in_load) begin
                r_wr_count <= r_wr_count + 8'd1;
                r_ptr      <= (r_state == c_LOAD_A);
            end
        end
    end

    assign enabling = r_enabling;
    assign wr_data  = r_wr_data;
    assign gnt_a    = r_gnt_a;
    assign gnt_b    = r_gnt_b;
    assign done_a   = r_done_a;
    assign done_b   = r_done_b;
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Self-checking bench for reg_write_arbiter: directed scenarios
//               plus randomized requesters against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int WIDTH = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_a = 1'b0;
    logic [WIDTH-1:0] data_a = '0;
    logic             req_b = 1'b0;
    logic [WIDTH-1:0] data_b = '0;
    logic             enabling;
    logic [WIDTH-1:0] wr_data;
    logic             gnt_a;
    logic             gnt_b;
    logic             done_a;
    logic             done_b;
    logic [7:0]       wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner 0 = nobody, 1 = A, 2 = B; age 1 = load cycle, >=2 = ack.
    int         m_owner = 0;
    int         m_age   = 0;
    int         m_ptr   = 0;
    int         m_cnt   = 0;
    logic [3:0] m_wdata = '0;

    reg_write_arbiter #(.WIDTH(WIDTH)) u_dut (
        .clock   (clock),
        .reset   (reset),
        .req_a   (req_a),
        .data_a  (data_a),
        .req_b   (req_b),
        .data_b  (data_b),
        .enabling(enabling),
        .wr_data (wr_data),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .done_a  (done_a),
        .done_b  (done_b),
        .wr_count(wr_count)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_owner = 0; m_age = 0; m_ptr = 0; m_cnt = 0; m_wdata = '0;
        end else if (m_owner == 0) begin
            if (req_a && (!req_b || m_ptr == 0)) begin
                m_owner = 1; m_age = 1; m_wdata = data_a;
            end else if (req_b) begin
                m_owner = 2; m_age = 1; m_wdata = data_b;
            end
        end else if (m_age == 1) begin
            m_age = 2;
            m_cnt = (m_cnt + 1) % 256;
            m_ptr = (m_owner == 1) ? 1 : 0;
        end else if ((m_owner == 1 && !req_a) || (m_owner == 2 && !req_b)) begin
            m_owner = 0; m_age = 0;
        end
    endtask

    function automatic logic m_done(input int who);
        return (m_owner == who) && (m_age >= 2);
    endfunction

    task automatic compare_all();
        chk("enabling", 32'(enabling), 32'((m_owner != 0) && (m_age == 1)));
        chk("wr_data",  32'(wr_data),  32'(m_wdata));
        chk("gnt_a",    32'(gnt_a),    32'(m_owner == 1));
        chk("gnt_b",    32'(gnt_b),    32'(m_owner == 2));
        chk("done_a",   32'(done_a),   32'(m_done(1)));
        chk("done_b",   32'(done_b),   32'(m_done(2)));
        chk("wr_count", 32'(wr_count), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    logic gq[$];
    int   pulses;

    initial begin
        // Reset state and single write from A.
        do_reset();
        req_a = 1'b1; data_a = 4'b1010;
        tick();
        chk("t028_en",  32'(enabling), 32'd1);
        chk("t028_wd",  32'(wr_data),  32'hA);
        chk("t028_gnt", 32'(gnt_a),    32'd1);
        tick();
        chk("t028_done", 32'(done_a),   32'd1);
        chk("t028_cnt",  32'(wr_count), 32'd1);
        tick(); tick();
        req_a = 1'b0;
        tick(); tick();

        // Both requesters continuously competing: strict alternation from A.
        do_reset();
        data_a = 4'h3; data_b = 4'hC;
        req_a = 1'b1; req_b = 1'b1;
        gq.delete();
        for (int i = 0; i < 60 && gq.size() < 8; i++) begin
            tick();
            if (enabling) begin
                chk("t029_wd", 32'(wr_data), (gq.size() % 2 == 1) ? 32'hC : 32'h3);
                gq.push_back(gnt_b);
            end
            req_a = !m_done(1);
            req_b = !m_done(2);
        end
        chk("t029_ngrants", 32'(gq.size()), 32'd8);
        foreach (gq[i]) chk("t029_order", 32'(gq[i]), 32'(i % 2));
        req_a = 1'b0; req_b = 1'b0;
        tick(); tick();

        // B holds its acknowledge while A waits.
        do_reset();
        req_b = 1'b1; data_b = 4'h5;
        tick(); tick();
        req_a = 1'b1; data_a = 4'h9;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t030_gnt_a", 32'(gnt_a), 32'd0);
            data_a = 4'($urandom);
        end
        req_b = 1'b0;
        tick();
        data_a = 4'h6;
        tick();
        chk("t030_a_granted", 32'(gnt_a), 32'd1);
        chk("t030_wd",        32'(wr_data), 32'h6);
        req_a = 1'b0;
        tick(); tick(); tick();

        // Reset arriving while LOAD_A is active.
        do_reset();
        req_a = 1'b1; data_a = 4'hF;
        tick();
        reset = 1'b1;
        tick();
        chk("t031_en",  32'(enabling), 32'd0);
        chk("t031_cnt", 32'(wr_count), 32'd0);
        chk("t031_gnt", 32'(gnt_a),    32'd0);
        reset = 1'b0; req_a = 1'b0;
        tick();

        // Counter wrap after 256 writes.
        do_reset();
        for (int w = 1; w <= 257; w++) begin
            req_a = 1'b1; data_a = 4'(w);
            for (int k = 0; k < 6 && !m_done(1); k++) tick();
            chk("t032_got_done", 32'(done_a), 32'd1);
            req_a = 1'b0;
            tick();
            if (w == 256) chk("t032_wrap", 32'(wr_count), 32'd0);
            if (w == 257) chk("t032_after", 32'(wr_count), 32'd1);
        end

        // One-cycle request pulse.
        do_reset();
        req_a = 1'b1; data_a = 4'h7;
        pulses = 0;
        tick();
        if (enabling) pulses++;
        req_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (enabling) pulses++;
        end
        chk("t033_pulses", 32'(pulses), 32'd1);

        // Randomized requesters, including early drops and random resets.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!req_a) req_a = ($urandom_range(0, 2) == 0);
            else if (m_done(1)) req_a = ($urandom_range(0, 1) == 0);
            else req_a = ($urandom_range(0, 19) != 0);
            if (!req_b) req_b = ($urandom_range(0, 2) == 0);
            else if (m_done(2)) req_b = ($urandom_range(0, 1) == 0);
            else req_b = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 2) == 0) data_a = 4'($urandom);
            if ($urandom_range(0, 2) == 0) data_b = 4'($urandom);
            tick();
            chk("excl_gnt", 32'(gnt_a && gnt_b), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, data width of the shared register write port.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req_a  input  1  requester A write request, level, held until done_a.
REQ-005 Port: data_a  input  WIDTH  requester A write data.
REQ-006 Port: req_b  input  1  requester B write request, level, held until done_b.
REQ-007 Port: data_b  input  WIDTH  requester B write data.
REQ-008 Port: enabling  output  1  write enable to the shared 4-bit D_FF register bank.
REQ-009 Port: wr_data  output  WIDTH  data to the register bank's D inputs (bit WIDTH-1 = MSB).
REQ-010 Port: gnt_a / gnt_b  output  1 each  grant indicators.
REQ-011 Port: done_a / done_b  output  1 each  write-complete acknowledge.
REQ-012 Port: wr_count  output  8  number of completed writes, modulo 256.

Function
REQ-013 FSM states SHALL be IDLE, LOAD_A, LOAD_B, ACK_A, ACK_B; all outputs SHALL be registered.
REQ-014 In IDLE with exactly one of req_a/req_b high, the FSM SHALL enter LOAD_A/LOAD_B at the next edge.
REQ-015 In IDLE with both requests high, the FSM SHALL grant the requester indicated by a 1-bit round-robin pointer (0 = A, 1 = B).
REQ-016 On entering LOAD_x, wr_data SHALL take data_x as sampled at that edge and hold it until the next grant.
REQ-017 In LOAD_x, enabling SHALL be 1 for exactly one cycle; enabling SHALL be 0 in all other states.
REQ-018 LOAD_x SHALL always advance to ACK_x after one cycle; wr_count SHALL increment (wrapping 255 -> 0) on that transition.
REQ-019 On LOAD_x -> ACK_x, the round-robin pointer SHALL be set to the other requester.
REQ-020 gnt_x SHALL be 1 in LOAD_x and ACK_x only; done_x SHALL be 1 in ACK_x only.
REQ-021 ACK_x SHALL remain until req_x is sampled low, then return to IDLE; IDLE SHALL last at least one cycle between grants.
REQ-022 A request dropped during LOAD_x SHALL NOT abort the write; ACK_x lasts one cycle, then IDLE.
REQ-023 The non-granted requester's data and request changes SHALL have no effect until the FSM returns to IDLE.
REQ-024 gnt_a and gnt_b SHALL never be 1 in the same cycle; done_x SHALL never be 1 without gnt_x.

Reset
REQ-025 With reset high at an edge, the state SHALL become IDLE and pointer 0; enabling, wr_data, gnt_a, gnt_b, done_a, done_b and wr_count SHALL be 0 in the following cycle.
REQ-026 Reset SHALL take priority over all transitions, including mid-LOAD (write suppressed, no count increment) and mid-ACK.
REQ-027 After reset release, the first simultaneous request SHALL go to A.

Verification
REQ-028 Reset, then req_a=1, data_a=4'b1010 -> next cycle enabling=1, wr_data=1010, gnt_a=1; then done_a=1 until req_a drops; wr_count=1.
REQ-029 Both requests held with data_a=3, data_b=C -> grants alternate A,B,A,B; each enabling pulse is 1 cycle; wr_data=3,C,3,C; no overlap of gnt_a/gnt_b.
REQ-030 req_b held in ACK_B for 10 cycles while req_a=1 -> gnt_a stays 0, enabling stays 0 until IDLE; then A granted.
REQ-031 reset asserted in the cycle LOAD_A is entered -> next cycle all outputs 0, wr_count unchanged from 0, state IDLE.
REQ-032 256 back-to-back single-requester writes -> wr_count wraps to 0; 257th write gives 1.
REQ-033 req_a pulsed for 1 cycle only -> exactly one enabling pulse, one-cycle done_a, return to IDLE.
